// File: rtl/dcache_pkg.sv
// Shared widths, tag-field layout and FSM encoding for the data-cache controller.
package dcache_pkg;
  localparam int ADDR_W    = 32;
  localparam int TAG_W     = 23;
  localparam int IDX_W     = 4;
  localparam int LINE_W    = 256;
  localparam int WORD_W    = 32;
  localparam int OFF_W     = 5;
  localparam int WSEL_W    = 3;
  localparam int WSEL_LSB  = 2;
  localparam int STAG_W    = 25;
  localparam int VALID_BIT = 24;
  localparam int DIRTY_BIT = 23;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    READMISS  = 2'd2,
    REFILL    = 2'd3
  } dc_state_t;
endpackage

// File: rtl/dcache_line_merge.sv
// Inserts a word into a cache line at a word index and extracts the word at that index.
module dcache_line_merge
  import dcache_pkg::*;
(
  input  logic [LINE_W-1:0] line,
  input  logic [WORD_W-1:0] wdata,
  input  logic [WSEL_W-1:0] sel,
  output logic [LINE_W-1:0] merged,
  output logic [WORD_W-1:0] rdata
);

  always_comb begin
    merged = line;
    merged[int'(sel)*WORD_W +: WORD_W] = wdata;
    rdata = line[int'(sel)*WORD_W +: WORD_W];
  end

endmodule

// File: rtl/dcache_controller.sv
// Control FSM in front of the 2-way dcache SRAM: hit service, dirty write-back and refill.
module dcache_controller
  import dcache_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [ADDR_W-1:0]   cpu_addr_i,
  input  logic [WORD_W-1:0]   cpu_data_i,
  input  logic                cpu_read_i,
  input  logic                cpu_write_i,
  output logic [WORD_W-1:0]   cpu_data_o,
  output logic                cpu_stall_o,
  output logic [IDX_W-1:0]    sram_idx_o,
  output logic [STAG_W-1:0]   sram_tag_o,
  output logic [LINE_W-1:0]   sram_data_o,
  output logic                sram_enable_o,
  output logic                sram_write_o,
  input  logic [STAG_W-1:0]   sram_tag_i,
  input  logic [LINE_W-1:0]   sram_data_i,
  input  logic                sram_hit_i,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [LINE_W-1:0]   mem_data_o,
  output logic                mem_enable_o,
  output logic                mem_write_o,
  input  logic [LINE_W-1:0]   mem_data_i,
  input  logic                mem_ack_i
);

  dc_state_t          state, state_nxt;
  logic [TAG_W-1:0]   victim_tag;
  logic [LINE_W-1:0]  victim_line;
  logic [LINE_W-1:0]  refill_line;
  logic [TAG_W-1:0]   tag;
  logic [IDX_W-1:0]   idx;
  logic [WSEL_W-1:0]  wsel;
  logic               req;
  logic               victim_dirty;
  logic               latch_victim;
  logic               latch_refill;
  logic [LINE_W-1:0]  merged_line;
  logic [WORD_W-1:0]  sel_word;
  logic               unused_ok;

  assign tag          = cpu_addr_i[ADDR_W-1 -: TAG_W];
  assign idx          = cpu_addr_i[OFF_W +: IDX_W];
  assign wsel         = cpu_addr_i[WSEL_LSB +: WSEL_W];
  assign req          = cpu_read_i | cpu_write_i;
  assign victim_dirty = sram_tag_i[VALID_BIT] & sram_tag_i[DIRTY_BIT];
  assign unused_ok    = &{1'b0, cpu_addr_i[WSEL_LSB-1:0]};

  dcache_line_merge u_merge (
    .line   (sram_data_i),
    .wdata  (cpu_data_i),
    .sel    (wsel),
    .merged (merged_line),
    .rdata  (sel_word)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state       <= IDLE;
      victim_tag  <= '0;
      victim_line <= '0;
    end else begin
      state <= state_nxt;
      if (latch_victim) begin
        victim_tag  <= sram_tag_i[TAG_W-1:0];
        victim_line <= sram_data_i;
      end
    end
  end

  // Refill buffer is pure data; it is only consumed in REFILL after being loaded.
  always_ff @(posedge clk_i) begin
    if (latch_refill) refill_line <= mem_data_i;
  end

  always_comb begin
    state_nxt    = state;
    latch_victim = 1'b0;
    latch_refill = 1'b0;
    case (state)
      IDLE: begin
        if (req && !sram_hit_i) begin
          if (victim_dirty) begin
            state_nxt    = WRITEBACK;
            latch_victim = 1'b1;
          end else begin
            state_nxt = READMISS;
          end
        end
      end
      WRITEBACK: if (mem_ack_i) state_nxt = READMISS;
      READMISS: begin
        if (mem_ack_i) begin
          state_nxt    = REFILL;
          latch_refill = 1'b1;
        end
      end
      REFILL:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cpu_stall_o   = 1'b0;
    sram_enable_o = 1'b0;
    sram_write_o  = 1'b0;
    sram_tag_o    = {1'b1, 1'b1, tag};
    sram_data_o   = merged_line;
    if (rst_i) begin
      case (state)
        IDLE: begin
          sram_enable_o = req;
          sram_write_o  = req & sram_hit_i & cpu_write_i;
          cpu_stall_o   = req & ~sram_hit_i;
        end
        REFILL: begin
          sram_enable_o = 1'b1;
          sram_write_o  = 1'b1;
          sram_tag_o    = {1'b1, 1'b0, tag};
          sram_data_o   = refill_line;
          cpu_stall_o   = 1'b1;
        end
        default: cpu_stall_o = 1'b1;
      endcase
    end
  end

  // The memory request is a pure decode of the registered state, so it drops with reset.
  assign cpu_data_o   = sel_word;
  assign sram_idx_o   = idx;
  assign mem_enable_o = (state == WRITEBACK) || (state == READMISS);
  assign mem_write_o  = (state == WRITEBACK);
  assign mem_addr_o   = {(state == WRITEBACK) ? victim_tag : tag, idx, {OFF_W{1'b0}}};
  assign mem_data_o   = victim_line;

endmodule

// File: tb/tb_dcache_controller.sv
// Directed bench for dcache_controller with a 2-way LRU SRAM model and a fixed-latency memory model.
module tb_dcache_controller;

  logic         clk = 1'b0;
  logic         rst_i;
  logic [31:0]  cpu_addr_i;
  logic [31:0]  cpu_data_i;
  logic         cpu_read_i;
  logic         cpu_write_i;
  logic [31:0]  cpu_data_o;
  logic         cpu_stall_o;
  logic [3:0]   sram_idx_o;
  logic [24:0]  sram_tag_o;
  logic [255:0] sram_data_o;
  logic         sram_enable_o;
  logic         sram_write_o;
  logic [24:0]  sram_tag_i;
  logic [255:0] sram_data_i;
  logic         sram_hit_i;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o;
  logic         mem_enable_o;
  logic         mem_write_o;
  logic [255:0] mem_data_i;
  logic         mem_ack_i;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dcache_controller dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .cpu_addr_i    (cpu_addr_i),
    .cpu_data_i    (cpu_data_i),
    .cpu_read_i    (cpu_read_i),
    .cpu_write_i   (cpu_write_i),
    .cpu_data_o    (cpu_data_o),
    .cpu_stall_o   (cpu_stall_o),
    .sram_idx_o    (sram_idx_o),
    .sram_tag_o    (sram_tag_o),
    .sram_data_o   (sram_data_o),
    .sram_enable_o (sram_enable_o),
    .sram_write_o  (sram_write_o),
    .sram_tag_i    (sram_tag_i),
    .sram_data_i   (sram_data_i),
    .sram_hit_i    (sram_hit_i),
    .mem_addr_o    (mem_addr_o),
    .mem_data_o    (mem_data_o),
    .mem_enable_o  (mem_enable_o),
    .mem_write_o   (mem_write_o),
    .mem_data_i    (mem_data_i),
    .mem_ack_i     (mem_ack_i)
  );

  // Memory content: word i of the line holding address a is (tag << 8) | (i + 1).
  function automatic logic [255:0] pat(input logic [31:0] a);
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = (32'(a[31:9]) << 8) | 32'(i + 1);
    return l;
  endfunction

  // 2-way SRAM model: LRU moves on hits and writes only.
  logic [24:0]  tag_mem  [16][2];
  logic [255:0] data_mem [16][2];
  logic         lru      [16];
  logic         sram_clear;
  logic         s_hit;
  logic         s_way;
  int           sram_writes = 0;

  always_comb begin
    s_hit = 1'b0;
    s_way = lru[sram_idx_o];
    for (int w = 0; w < 2; w++) begin
      if (tag_mem[sram_idx_o][w][24] && tag_mem[sram_idx_o][w][22:0] == sram_tag_o[22:0]) begin
        s_hit = 1'b1;
        s_way = 1'(w);
      end
    end
  end

  assign sram_hit_i  = s_hit;
  assign sram_tag_i  = tag_mem[sram_idx_o][s_way];
  assign sram_data_i = data_mem[sram_idx_o][s_way];

  always @(posedge clk) begin
    if (sram_clear) begin
      for (int i = 0; i < 16; i++) begin
        tag_mem[i][0] <= '0;
        tag_mem[i][1] <= '0;
        lru[i]        <= 1'b0;
      end
    end else if (sram_enable_o && (s_hit || sram_write_o)) begin
      if (sram_write_o) begin
        tag_mem[sram_idx_o][s_way]  <= sram_tag_o;
        data_mem[sram_idx_o][s_way] <= sram_data_o;
        sram_writes <= sram_writes + 1;
      end
      lru[sram_idx_o] <= ~s_way;
    end
  end

  // Memory model: ack after mem_lat cycles of enable, one-cycle pulse.
  int           mem_lat = 10;
  int           mcnt = 0;
  logic         ack_model = 1'b0;
  logic         ack_force;
  logic [255:0] mem_rdata = '0;

  always @(posedge clk) begin
    if (ack_model) begin
      ack_model <= 1'b0;
    end else if (mem_enable_o) begin
      if (mcnt + 1 >= mem_lat) begin
        ack_model <= 1'b1;
        mcnt      <= 0;
        if (!mem_write_o) mem_rdata <= pat(mem_addr_o);
      end else begin
        mcnt <= mcnt + 1;
      end
    end else begin
      mcnt <= 0;
    end
  end

  assign mem_ack_i  = ack_model | ack_force;
  assign mem_data_i = mem_rdata;

  task automatic test_reset();
    rst_i = 1'b0; sram_clear = 1'b1; ack_force = 1'b0;
    cpu_addr_i = 32'h40; cpu_data_i = '0; cpu_read_i = 1'b1; cpu_write_i = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    total++; if (cpu_stall_o !== 1'b0) begin bad++; $display("FAIL rst_stall got=%b exp=0", cpu_stall_o); end
    total++; if (sram_enable_o !== 1'b0) begin bad++; $display("FAIL rst_sram_en got=%b exp=0", sram_enable_o); end
    total++; if (sram_write_o !== 1'b0) begin bad++; $display("FAIL rst_sram_wr got=%b exp=0", sram_write_o); end
    total++; if (mem_enable_o !== 1'b0) begin bad++; $display("FAIL rst_mem_en got=%b exp=0", mem_enable_o); end
    total++; if (mem_write_o !== 1'b0) begin bad++; $display("FAIL rst_mem_wr got=%b exp=0", mem_write_o); end
    @(negedge clk);
    rst_i = 1'b1; sram_clear = 1'b0; cpu_read_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_cold_read();
    int n;
    mem_lat = 10;
    cpu_addr_i = 32'h40; cpu_read_i = 1'b1;
    #1;
    total++; if (cpu_stall_o !== 1'b1) begin bad++; $display("FAIL t1_stall got=%b exp=1", cpu_stall_o); end
    n = 0;
    while (!mem_enable_o && n < 100) begin @(negedge clk); #1; n++; end
    total++; if (!mem_enable_o) begin bad++; $display("FAIL t1_mem_req_timeout got=0 exp=1"); end
    total++; if (mem_addr_o !== 32'h40) begin bad++; $display("FAIL t1_mem_addr got=%h exp=00000040", mem_addr_o); end
    total++; if (mem_write_o !== 1'b0) begin bad++; $display("FAIL t1_mem_wr got=%b exp=0", mem_write_o); end
    n = 0;
    while (!(sram_write_o && cpu_stall_o) && n < 100) begin @(negedge clk); #1; n++; end
    total++; if (!(sram_write_o && cpu_stall_o)) begin bad++; $display("FAIL t1_refill_timeout got=0 exp=1"); end
    total++; if (sram_tag_o !== 25'h1000000) begin bad++; $display("FAIL t1_refill_tag got=%h exp=1000000", sram_tag_o); end
    total++; if (sram_data_o !== pat(32'h40)) begin bad++; $display("FAIL t1_refill_line got=%h exp=%h", sram_data_o, pat(32'h40)); end
    @(negedge clk); #1;
    total++; if (cpu_stall_o !== 1'b0) begin bad++; $display("FAIL t1_hit_stall got=%b exp=0", cpu_stall_o); end
    total++; if (cpu_data_o !== 32'h1) begin bad++; $display("FAIL t1_hit_data got=%h exp=00000001", cpu_data_o); end
    @(negedge clk);
    cpu_read_i = 1'b0;
  endtask

  task automatic test_store_hit();
    logic [255:0] exp;
    exp = pat(32'h40);
    exp[63:32] = 32'hDEADBEEF;
    @(negedge clk);
    cpu_addr_i = 32'h44; cpu_data_i = 32'hDEADBEEF; cpu_write_i = 1'b1;
    #1;
    total++; if (cpu_stall_o !== 1'b0) begin bad++; $display("FAIL t2_stall got=%b exp=0", cpu_stall_o); end
    total++; if (sram_write_o !== 1'b1) begin bad++; $display("FAIL t2_sram_wr got=%b exp=1", sram_write_o); end
    total++; if (sram_tag_o !== 25'h1800000) begin bad++; $display("FAIL t2_tag got=%h exp=1800000", sram_tag_o); end
    total++; if (sram_data_o !== exp) begin bad++; $display("FAIL t2_line got=%h exp=%h", sram_data_o, exp); end
    @(negedge clk);
    cpu_write_i = 1'b0; cpu_read_i = 1'b1;
    #1;
    total++; if (cpu_data_o !== 32'hDEADBEEF) begin bad++; $display("FAIL t2_readback got=%h exp=deadbeef", cpu_data_o); end
    @(negedge clk);
    cpu_read_i = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      cpu_addr_i = 32'h40 + 32'(i * 4); cpu_read_i = 1'b1;
      exp = (i == 1) ? 32'hDEADBEEF : 32'(i + 1);
      #1;
      total++; if (cpu_stall_o !== 1'b0) begin bad++; $display("FAIL t4_stall_w%0d got=%b exp=0", i, cpu_stall_o); end
      total++; if (cpu_data_o !== exp) begin bad++; $display("FAIL t4_data_w%0d got=%h exp=%h", i, cpu_data_o, exp); end
    end
    @(negedge clk);
    cpu_read_i = 1'b0;
  endtask

  task automatic store_through(input logic [31:0] a, input logic [31:0] d);
    int n;
    @(negedge clk);
    cpu_addr_i = a; cpu_data_i = d; cpu_write_i = 1'b1;
    #1;
    n = 0;
    while (cpu_stall_o && n < 100) begin @(negedge clk); #1; n++; end
    total++; if (!(sram_write_o && sram_tag_o[23])) begin bad++; $display("FAIL t3_fill_store_%h got=%b exp=1", a, sram_write_o); end
    @(negedge clk);
    cpu_write_i = 1'b0;
  endtask

  task automatic test_dirty_evict();
    int n;
    logic [255:0] exp;
    @(negedge clk); sram_clear = 1'b1;
    @(negedge clk); sram_clear = 1'b0;
    mem_lat = 3;
    store_through(32'h240, 32'h1111_1111);
    store_through(32'h440, 32'h2222_2222);
    exp = pat(32'h240);
    exp[31:0] = 32'h1111_1111;
    @(negedge clk);
    cpu_addr_i = 32'h640; cpu_read_i = 1'b1;
    #1;
    n = 0;
    while (!(mem_enable_o && mem_write_o) && n < 100) begin @(negedge clk); #1; n++; end
    total++; if (!(mem_enable_o && mem_write_o)) begin bad++; $display("FAIL t3_wb_timeout got=0 exp=1"); end
    total++; if (mem_addr_o !== 32'h240) begin bad++; $display("FAIL t3_wb_addr got=%h exp=00000240", mem_addr_o); end
    total++; if (mem_data_o !== exp) begin bad++; $display("FAIL t3_wb_line got=%h exp=%h", mem_data_o, exp); end
    n = 0;
    while (!(mem_enable_o && !mem_write_o) && n < 100) begin @(negedge clk); #1; n++; end
    total++; if (mem_addr_o !== 32'h640 || mem_write_o !== 1'b0) begin bad++; $display("FAIL t3_rd_addr got=%h exp=00000640", mem_addr_o); end
    n = 0;
    while (cpu_stall_o && n < 100) begin @(negedge clk); #1; n++; end
    total++; if (cpu_stall_o !== 1'b0) begin bad++; $display("FAIL t3_hit_timeout got=1 exp=0"); end
    total++; if (cpu_data_o !== 32'h301) begin bad++; $display("FAIL t3_hit_data got=%h exp=00000301", cpu_data_o); end
    @(negedge clk);
    cpu_read_i = 1'b0;
  endtask

  task automatic test_reset_mid_wb();
    int n;
    int wcount;
    mem_lat = 20;
    @(negedge clk);
    cpu_addr_i = 32'h840; cpu_read_i = 1'b1;
    #1;
    n = 0;
    while (!(mem_enable_o && mem_write_o) && n < 100) begin @(negedge clk); #1; n++; end
    total++; if (mem_addr_o !== 32'h440 || !mem_write_o) begin bad++; $display("FAIL t5_wb_addr got=%h exp=00000440", mem_addr_o); end
    @(negedge clk);
    wcount = sram_writes;
    rst_i = 1'b0;
    #1;
    total++; if ({cpu_stall_o, sram_enable_o, sram_write_o} !== 3'b000) begin bad++; $display("FAIL t5_forced_low got=%b exp=000", {cpu_stall_o, sram_enable_o, sram_write_o}); end
    @(negedge clk); #1;
    total++; if ({mem_enable_o, mem_write_o} !== 2'b00) begin bad++; $display("FAIL t5_mem_drop got=%b exp=00", {mem_enable_o, mem_write_o}); end
    rst_i = 1'b1; cpu_read_i = 1'b0; ack_force = 1'b1;
    @(negedge clk);
    ack_force = 1'b0;
    #1;
    total++; if ({mem_enable_o, cpu_stall_o} !== 2'b00) begin bad++; $display("FAIL t5_late_ack got=%b exp=00", {mem_enable_o, cpu_stall_o}); end
    @(negedge clk); #1;
    total++; if (sram_writes !== wcount) begin bad++; $display("FAIL t5_no_sram_write got=%0d exp=%0d", sram_writes, wcount); end
    cpu_addr_i = 32'h640; cpu_read_i = 1'b1;
    #1;
    total++; if (cpu_stall_o !== 1'b0 || cpu_data_o !== 32'h301) begin bad++; $display("FAIL t5_idle_hit got=%b/%h exp=0/00000301", cpu_stall_o, cpu_data_o); end
    @(negedge clk);
    cpu_read_i = 1'b0;
  endtask

  task automatic test_rw_fast_ack();
    int n;
    @(negedge clk); sram_clear = 1'b1;
    @(negedge clk); sram_clear = 1'b0;
    mem_lat = 1;
    cpu_addr_i = 32'hA88; cpu_data_i = 32'hCAFEF00D; cpu_read_i = 1'b1; cpu_write_i = 1'b1;
    #1;
    total++; if (cpu_stall_o !== 1'b1 || sram_write_o !== 1'b0) begin bad++; $display("FAIL t6_miss got=%b%b exp=10", cpu_stall_o, sram_write_o); end
    n = 0;
    while (!mem_enable_o && n < 100) begin @(negedge clk); #1; n++; end
    total++; if (mem_addr_o !== 32'hA80 || mem_write_o !== 1'b0) begin bad++; $display("FAIL t6_rd_addr got=%h exp=00000a80", mem_addr_o); end
    n = 0;
    while (!(sram_write_o && cpu_stall_o) && n < 100) begin @(negedge clk); #1; n++; end
    total++; if (sram_tag_o !== 25'h1000005 || !sram_write_o) begin bad++; $display("FAIL t6_refill_tag got=%h exp=1000005", sram_tag_o); end
    @(negedge clk); #1;
    total++; if (cpu_stall_o !== 1'b0 || sram_write_o !== 1'b1) begin bad++; $display("FAIL t6_store_hit got=%b%b exp=01", cpu_stall_o, sram_write_o); end
    total++; if (sram_tag_o !== 25'h1800005) begin bad++; $display("FAIL t6_dirty_tag got=%h exp=1800005", sram_tag_o); end
    total++; if (sram_data_o[95:64] !== 32'hCAFEF00D || sram_data_o[31:0] !== 32'h501) begin bad++; $display("FAIL t6_line got=%h exp=cafef00d/00000501", sram_data_o[95:64]); end
    @(negedge clk);
    cpu_write_i = 1'b0;
    #1;
    total++; if (cpu_data_o !== 32'hCAFEF00D) begin bad++; $display("FAIL t6_readback got=%h exp=cafef00d", cpu_data_o); end
    @(negedge clk);
    cpu_read_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_cold_read();
    test_store_hit();
    test_back_to_back();
    test_dirty_evict();
    test_reset_mid_wb();
    test_rw_fast_ack();
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
